// File: rtl/uart_frame_chk.sv
// UART receive frame checker/deserialiser: start-glitch, parity and stop-bit checks per frame.
// Optional saturating error counters are built only when FRAME_CHK_ERR_CNT_EN is defined.
module uart_frame_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_bit_valid,
  input  logic                  i_sampled_bit,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
`ifdef FRAME_CHK_ERR_CNT_EN
  input  logic                  i_cnt_clr,
  output logic [CNT_WIDTH-1:0]  o_glitch_cnt,
  output logic [CNT_WIDTH-1:0]  o_par_err_cnt,
  output logic [CNT_WIDTH-1:0]  o_stp_err_cnt,
`endif
  output logic [DATA_WIDTH-1:0] o_p_data,
  output logic                  o_data_valid,
  output logic                  o_strt_glitch,
  output logic                  o_par_err,
  output logic                  o_stp_err,
  output logic                  o_busy,
  output logic [1:0]            o_dbg_state
);

  // Input handshake: i_bit_valid is a single-cycle qualifier with no back-pressure;
  // i_sampled_bit is meaningful only while i_bit_valid is high.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int BCW = $clog2(DATA_WIDTH);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BCW-1:0]        r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_fault;
  logic                  r_stp_fault;

  logic w_glitch;
  logic w_last_stop;
  logic w_frame_end;
  logic w_stp_fault;
  logic w_par_err_end;
  logic w_stp_err_end;

  assign w_glitch      = (r_state == IDLE) && i_bit_valid && i_sampled_bit;
  assign w_last_stop   = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;
  assign w_frame_end   = (r_state == STOP) && i_bit_valid && w_last_stop;
  assign w_stp_fault   = r_stp_fault | ~i_sampled_bit;
  assign w_par_err_end = w_frame_end && r_par_en && r_par_fault;
  assign w_stp_err_end = w_frame_end && w_stp_fault;

  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_stop_cnt    <= 1'b0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_par_fault   <= 1'b0;
      r_stp_fault   <= 1'b0;
      o_p_data      <= '0;
      o_data_valid  <= 1'b0;
      o_strt_glitch <= 1'b0;
      o_par_err     <= 1'b0;
      o_stp_err     <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_data_valid  <= 1'b0;
      o_strt_glitch <= 1'b0;
      o_par_err     <= 1'b0;
      o_stp_err     <= 1'b0;
      if (i_bit_valid) begin
        case (r_state)
          IDLE: begin
            if (i_sampled_bit) begin
              o_strt_glitch <= 1'b1;
            end else begin
              r_par_en    <= i_par_en;
              r_par_typ   <= i_par_typ;
              r_bit_cnt   <= '0;
              r_stop_cnt  <= 1'b0;
              r_par_fault <= 1'b0;
              r_stp_fault <= 1'b0;
              o_busy      <= 1'b1;
              r_state     <= DATA;
            end
          end
          DATA: begin
            r_shift   <= {i_sampled_bit, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              r_state <= r_par_en ? PARITY : STOP;
            end
          end
          PARITY: begin
            r_par_fault <= ((^r_shift) ^ i_sampled_bit) != r_par_typ;
            r_state     <= STOP;
          end
          STOP: begin
            // Every stop bit is consumed even after a fault so framing stays aligned.
            if (w_last_stop) begin
              o_p_data     <= r_shift;
              o_par_err    <= w_par_err_end;
              o_stp_err    <= w_stp_err_end;
              o_data_valid <= !(w_par_err_end || w_stp_err_end);
              o_busy       <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_stop_cnt  <= 1'b1;
              r_stp_fault <= w_stp_fault;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef FRAME_CHK_ERR_CNT_EN
  // Counters step on the same edge their pulse rises; clear wins over increment.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_cnt_clr) begin
      o_glitch_cnt  <= '0;
      o_par_err_cnt <= '0;
      o_stp_err_cnt <= '0;
    end else begin
      if (w_glitch && !(&o_glitch_cnt))       o_glitch_cnt  <= o_glitch_cnt + 1'b1;
      if (w_par_err_end && !(&o_par_err_cnt)) o_par_err_cnt <= o_par_err_cnt + 1'b1;
      if (w_stp_err_end && !(&o_stp_err_cnt)) o_stp_err_cnt <= o_stp_err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_chk.sv
// Bench for uart_frame_chk: one 8N1 instance and one 8-data/2-stop instance, directed plus random frames.
module tb_uart_frame_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, v1, v2, sbit, pe, pt, clr;
  logic [7:0] pd1, pd2;
  logic dv1, g1, pe1, se1, b1, dv2, g2, pe2, se2, b2;
  logic [1:0] st1, st2;
`ifdef FRAME_CHK_ERR_CNT_EN
  logic [1:0] gc1, pc1, sc1;
  logic [7:0] gc2, pc2, sc2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

`ifdef FRAME_CHK_ERR_CNT_EN
  uart_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_bit_valid(v1), .i_sampled_bit(sbit),
    .i_par_en(pe), .i_par_typ(pt), .i_cnt_clr(clr),
    .o_glitch_cnt(gc1), .o_par_err_cnt(pc1), .o_stp_err_cnt(sc1),
    .o_p_data(pd1), .o_data_valid(dv1), .o_strt_glitch(g1), .o_par_err(pe1),
    .o_stp_err(se1), .o_busy(b1), .o_dbg_state(st1));
  uart_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(8)) u2 (
    .i_clk(clk), .i_rst(rst), .i_bit_valid(v2), .i_sampled_bit(sbit),
    .i_par_en(pe), .i_par_typ(pt), .i_cnt_clr(clr),
    .o_glitch_cnt(gc2), .o_par_err_cnt(pc2), .o_stp_err_cnt(sc2),
    .o_p_data(pd2), .o_data_valid(dv2), .o_strt_glitch(g2), .o_par_err(pe2),
    .o_stp_err(se2), .o_busy(b2), .o_dbg_state(st2));
`else
  uart_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_bit_valid(v1), .i_sampled_bit(sbit),
    .i_par_en(pe), .i_par_typ(pt),
    .o_p_data(pd1), .o_data_valid(dv1), .o_strt_glitch(g1), .o_par_err(pe1),
    .o_stp_err(se1), .o_busy(b1), .o_dbg_state(st1));
  uart_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_bit_valid(v2), .i_sampled_bit(sbit),
    .i_par_en(pe), .i_par_typ(pt),
    .o_p_data(pd2), .o_data_valid(dv2), .o_strt_glitch(g2), .o_par_err(pe2),
    .o_stp_err(se2), .o_busy(b2), .o_dbg_state(st2));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the bit was consumed.
  task automatic drive_bit(input int dut, input logic b);
    sbit = b;
    if (dut == 1) v1 = 1'b1; else v2 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic sample(input int dut, output logic dv, output logic g, output logic perr,
                        output logic serr, output logic bsy, output logic [7:0] pd);
    if (dut == 1) begin dv = dv1; g = g1; perr = pe1; serr = se1; bsy = b1; pd = pd1; end
    else          begin dv = dv2; g = g2; perr = pe2; serr = se2; bsy = b2; pd = pd2; end
  endtask

  task automatic check_quiet(input int dut, input string tag);
    logic dv, g, perr, serr, bsy;
    logic [7:0] pd;
    sample(dut, dv, g, perr, serr, bsy, pd);
    chk({tag, "_pulses"}, {28'd0, dv, g, perr, serr}, 32'd0);
  endtask

  task automatic send_frame(input int dut, input logic [7:0] d, input logic fpe, input logic fpt,
                            input logic pbit, input logic [1:0] stops, input string tag);
    int nstop;
    int ones;
    logic e_par, e_stp;
    logic dv, g, perr, serr, bsy;
    logic [7:0] pd;
    nstop = (dut == 1) ? 1 : 2;
    ones  = $countones(d) + int'(pbit);
    e_par = fpe && ((ones % 2) != int'(fpt));
    e_stp = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    exp_q.push_back(d);
    pe = fpe;
    pt = fpt;
    drive_bit(dut, 1'b0);
    sample(dut, dv, g, perr, serr, bsy, pd);
    chk({tag, "_busy_rise"}, {31'd0, bsy}, 32'd1);
    pe = 1'($urandom);
    pt = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      drive_bit(dut, d[i]);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    if (fpe) drive_bit(dut, pbit);
    for (int s = 0; s < nstop; s++) begin
      drive_bit(dut, stops[s]);
      sample(dut, dv, g, perr, serr, bsy, pd);
      if (s < nstop - 1) begin
        chk({tag, "_mid_stop_busy"}, {31'd0, bsy}, 32'd1);
        chk({tag, "_mid_stop_pulses"}, {29'd0, dv, perr, serr}, 32'd0);
      end
    end
    chk({tag, "_data_valid"}, {31'd0, dv}, {31'd0, !(e_par || e_stp)});
    chk({tag, "_par_err"}, {31'd0, perr}, {31'd0, e_par});
    chk({tag, "_stp_err"}, {31'd0, serr}, {31'd0, e_stp});
    chk({tag, "_busy_fall"}, {31'd0, bsy}, 32'd0);
    chk({tag, "_p_data"}, {24'd0, pd}, {24'd0, exp_q.pop_front()});
    @(negedge clk);
    check_quiet(dut, {tag, "_after"});
  endtask

  task automatic glitch(input int dut, input string tag);
    logic dv, g, perr, serr, bsy;
    logic [7:0] pd;
    drive_bit(dut, 1'b1);
    sample(dut, dv, g, perr, serr, bsy, pd);
    chk({tag, "_strt_glitch"}, {31'd0, g}, 32'd1);
    chk({tag, "_busy"}, {31'd0, bsy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; v1 = 1'b0; v2 = 1'b0; sbit = 1'b1; pe = 1'b0; pt = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_u1", {20'd0, pd1, dv1, g1, pe1, se1}, 32'd0);
    chk("rst_u1_busy", {31'd0, b1}, 32'd0);
    chk("rst_u2", {19'd0, pd2, dv2, g2, pe2, se2, b2}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

`ifdef FRAME_CHK_ERR_CNT_EN
    chk("cnt_rst", {26'd0, gc1, pc1, sc1}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      glitch(1, "cnt_glitch");
      chk("glitch_cnt", {30'd0, gc1}, (k < 3) ? k : 3);
    end
    clr = 1'b1;
    glitch(1, "cnt_clr_glitch");
    clr = 1'b0;
    chk("glitch_cnt_clr", {30'd0, gc1}, 32'd0);
`endif

    send_frame(1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b11, "a5_8n1");
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b0, 2'b11, "a5_even_ok");
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1, 2'b11, "a5_even_bad");
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1, 2'b11, "a5_odd_ok");
    glitch(1, "glitch");
    @(negedge clk);
    check_quiet(1, "glitch_after");
    send_frame(1, 8'hC3, 1'b0, 1'b0, 1'b0, 2'b11, "post_glitch");
    send_frame(1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, "stop_zero");
    send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b01, "3c_stop2_bad");
    send_frame(2, 8'h3C, 1'b1, 1'b1, 1'b1, 2'b11, "3c_stop2_ok");

    // Abort a frame with reset after four data bits.
    pe = 1'b0;
    drive_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1, 1'(i));
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, b1}, 32'd0);
    chk("abort_p_data", {24'd0, pd1}, 32'd0);
    check_quiet(1, "abort");
    rst = 1'b1;
    @(negedge clk);
    check_quiet(1, "abort_release");
    send_frame(1, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b11, "post_abort");

    for (int r = 0; r < 16; r++) begin
      send_frame(1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 {1'b1, 1'($urandom_range(0, 3) != 0)}, "rand_u1");
      if ($urandom_range(0, 3) == 0) glitch(1, "rand_glitch");
    end
    for (int r = 0; r < 8; r++) begin
      send_frame(2, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)}, "rand_u2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
